// File: rtl/iwdg_pkg.sv
// Shared constants and state type for the hardware IWDG bring-up/refresh initiator.
package iwdg_pkg;

  localparam int KR_W  = 16;
  localparam int PR_W  = 3;
  localparam int RLR_W = 12;
  localparam int ST_W  = 2;

  localparam logic [KR_W-1:0] KEY_ACCESS = 16'h5555;
  localparam logic [KR_W-1:0] KEY_RELOAD = 16'hAAAA;
  localparam logic [KR_W-1:0] KEY_START  = 16'hCCCC;

  localparam logic [31:0] KR_OFS  = 32'h0;
  localparam logic [31:0] PR_OFS  = 32'h4;
  localparam logic [31:0] RLR_OFS = 32'h8;
  localparam logic [31:0] ST_OFS  = 32'hC;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_UNLOCK,
    ST_WR_RLR,
    ST_WR_PR,
    ST_POLL,
    ST_RELOAD,
    ST_STARTWD,
    ST_RUN,
    ST_KICK,
    ST_ERROR
  } iwdg_state_e;

endpackage

// File: rtl/wb_single_xfer.sv
// One-shot Wishbone access engine: launches a single read or write on req and
// reports done (with read data) or timeout when no ack arrives in time.
module wb_single_xfer #(
  parameter int DAT_SIZE    = 16,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                req_we,
  input  logic [31:0]         req_adr,
  input  logic [DAT_SIZE-1:0] req_dat,
  output logic                done,
  output logic                timeout,
  output logic [DAT_SIZE-1:0] rd_dat,
  output logic [DAT_SIZE-1:0] dat_m2s,
  output logic [31:0]         adr_m2s,
  output logic                cyc_m2s,
  output logic                stb_m2s,
  output logic                we_m2s,
  input  logic [DAT_SIZE-1:0] dat_s2m,
  input  logic                ack_s2m
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] wait_cnt;

  // ack is only honoured while a cycle is open; a new request is accepted only when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done     <= 1'b0;
      timeout  <= 1'b0;
      rd_dat   <= '0;
      dat_m2s  <= '0;
      adr_m2s  <= '0;
      cyc_m2s  <= 1'b0;
      stb_m2s  <= 1'b0;
      we_m2s   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      if (cyc_m2s) begin
        if (ack_s2m) begin
          cyc_m2s <= 1'b0;
          stb_m2s <= 1'b0;
          done    <= 1'b1;
          rd_dat  <= dat_s2m;
        end else if (wait_cnt == WAIT_LAST) begin
          cyc_m2s <= 1'b0;
          stb_m2s <= 1'b0;
          timeout <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + TW'(1);
        end
      end else if (req) begin
        adr_m2s  <= req_adr;
        dat_m2s  <= req_dat;
        we_m2s   <= req_we;
        cyc_m2s  <= 1'b1;
        stb_m2s  <= 1'b1;
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/iwdg_wb_init.sv
// Hardware replacement for the IWDG software driver: runs the key/RLR/PR/poll/
// reload/start sequence on start, then refreshes the watchdog while kick_en is high.
module iwdg_wb_init
  import iwdg_pkg::*;
#(
  parameter logic [31:0] BASE_ADR     = 32'h0100_0000,
  parameter logic [31:0] IWDG_KR_ADR  = BASE_ADR + KR_OFS,
  parameter logic [31:0] IWDG_PR_ADR  = BASE_ADR + PR_OFS,
  parameter logic [31:0] IWDG_RLR_ADR = BASE_ADR + RLR_OFS,
  parameter logic [31:0] IWDG_ST_ADR  = BASE_ADR + ST_OFS,
  parameter int          DAT_SIZE     = 16,
  parameter int          KICK_PERIOD  = 200,
  parameter int          ACK_TIMEOUT  = 16,
  parameter int          POLL_MAX     = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [RLR_W-1:0]    cfg_rlr,
  input  logic [PR_W-1:0]     cfg_pr,
  input  logic                kick_en,
  output logic [DAT_SIZE-1:0] dat_m2s,
  output logic [31:0]         adr_m2s,
  output logic                cyc_m2s,
  output logic                stb_m2s,
  output logic                we_m2s,
  input  logic [DAT_SIZE-1:0] dat_s2m,
  input  logic                ack_s2m,
  output logic                busy,
  output logic                running,
  output logic                err,
  output logic [15:0]         kick_cnt
);

  localparam int KTW = $clog2(KICK_PERIOD);
  localparam logic [KTW-1:0] KICK_LAST = KTW'(KICK_PERIOD - 1);
  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);
  localparam logic [DAT_SIZE-1:0] ST_MASK = DAT_SIZE'((1 << ST_W) - 1);

  iwdg_state_e        state;
  logic [RLR_W-1:0]   rlr_q;
  logic [PR_W-1:0]    pr_q;
  logic [KTW-1:0]     timer;
  logic [PCW-1:0]     poll_cnt;
  logic               pending;
  logic               req;
  logic               acc_we;
  logic [31:0]        acc_adr;
  logic [DAT_SIZE-1:0] acc_dat;
  logic               xfer_done;
  logic               xfer_timeout;
  logic [DAT_SIZE-1:0] rd_dat;

  always_comb begin
    acc_we  = 1'b1;
    acc_adr = IWDG_KR_ADR;
    acc_dat = DAT_SIZE'(KEY_ACCESS);
    case (state)
      ST_WR_RLR: begin
        acc_adr = IWDG_RLR_ADR;
        acc_dat = DAT_SIZE'(rlr_q);
      end
      ST_WR_PR: begin
        acc_adr = IWDG_PR_ADR;
        acc_dat = DAT_SIZE'(pr_q);
      end
      ST_POLL: begin
        acc_we  = 1'b0;
        acc_adr = IWDG_ST_ADR;
        acc_dat = '0;
      end
      ST_RELOAD, ST_KICK: acc_dat = DAT_SIZE'(KEY_RELOAD);
      ST_STARTWD:         acc_dat = DAT_SIZE'(KEY_START);
      default: ;
    endcase
  end

  // Bus states issue one access (pending marks it in flight) and advance on its completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rlr_q    <= '0;
      pr_q     <= '0;
      timer    <= '0;
      poll_cnt <= '0;
      pending  <= 1'b0;
      req      <= 1'b0;
      busy     <= 1'b0;
      running  <= 1'b0;
      err      <= 1'b0;
      kick_cnt <= '0;
    end else begin
      req <= 1'b0;
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            state    <= ST_UNLOCK;
            rlr_q    <= cfg_rlr;
            pr_q     <= cfg_pr;
            err      <= 1'b0;
            kick_cnt <= '0;
            pending  <= 1'b0;
            busy     <= 1'b1;
            running  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!kick_en) begin
            timer <= '0;
          end else if (timer == KICK_LAST) begin
            timer <= '0;
            state <= ST_KICK;
          end else begin
            timer <= timer + KTW'(1);
          end
        end
        default: begin
          if (!pending) begin
            req     <= 1'b1;
            pending <= 1'b1;
          end else if (xfer_timeout) begin
            pending <= 1'b0;
            state   <= ST_ERROR;
            err     <= 1'b1;
            busy    <= 1'b0;
            running <= 1'b0;
          end else if (xfer_done) begin
            pending <= 1'b0;
            case (state)
              ST_UNLOCK: state <= ST_WR_RLR;
              ST_WR_RLR: state <= ST_WR_PR;
              ST_WR_PR: begin
                state    <= ST_POLL;
                poll_cnt <= '0;
              end
              ST_POLL: begin
                if ((rd_dat & ST_MASK) == '0) begin
                  state <= ST_RELOAD;
                end else if (poll_cnt == POLL_LAST) begin
                  state <= ST_ERROR;
                  err   <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  poll_cnt <= poll_cnt + PCW'(1);
                end
              end
              ST_RELOAD: state <= ST_STARTWD;
              ST_STARTWD: begin
                state   <= ST_RUN;
                timer   <= '0;
                busy    <= 1'b0;
                running <= 1'b1;
              end
              ST_KICK: begin
                state    <= ST_RUN;
                timer    <= '0;
                kick_cnt <= kick_cnt + 16'd1;
              end
              default: state <= ST_ERROR;
            endcase
          end
        end
      endcase
    end
  end

  wb_single_xfer #(
    .DAT_SIZE    (DAT_SIZE),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_xfer (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_we  (acc_we),
    .req_adr (acc_adr),
    .req_dat (acc_dat),
    .done    (xfer_done),
    .timeout (xfer_timeout),
    .rd_dat  (rd_dat),
    .dat_m2s (dat_m2s),
    .adr_m2s (adr_m2s),
    .cyc_m2s (cyc_m2s),
    .stb_m2s (stb_m2s),
    .we_m2s  (we_m2s),
    .dat_s2m (dat_s2m),
    .ack_s2m (ack_s2m)
  );

endmodule
